// File: rtl/tilemem_writer_pkg.sv
// Shared definitions for the tile RAM console writer: control codes,
// FSM state encodings and the byte classifier.
package tilemem_writer_pkg;

    localparam logic [7:0] CH_BS   = 8'h08;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_FF   = 8'h0C;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_FILL = 8'h20;
    localparam logic [7:0] CH_DEL  = 8'h7F;

    typedef enum logic [1:0] {
        TW_CLRALL = 2'd0,
        TW_IDLE   = 2'd1,
        TW_CLRLN  = 2'd2
    } tw_state_e;

    typedef enum logic [2:0] {
        CC_PRINT  = 3'd0,
        CC_CR     = 3'd1,
        CC_LF     = 3'd2,
        CC_BS     = 3'd3,
        CC_FF     = 3'd4,
        CC_IGNORE = 3'd5
    } char_class_e;

    // Printable means 0x20..0x7E or anything with bit 7 set; the remaining
    // control codes (and DEL) are ignored unless they are one of the four
    // recognised ones.
    function automatic char_class_e classify(input logic [7:0] b);
        char_class_e c;
        if (b == CH_CR) begin
            c = CC_CR;
        end else if (b == CH_LF) begin
            c = CC_LF;
        end else if (b == CH_BS) begin
            c = CC_BS;
        end else if (b == CH_FF) begin
            c = CC_FF;
        end else if ((b >= 8'h20) && (b != CH_DEL)) begin
            c = CC_PRINT;
        end else begin
            c = CC_IGNORE;
        end
        return c;
    endfunction

endpackage

// File: rtl/tilemem_writer_if.sv
// Byte-stream input and tile RAM write-port bundle of the console writer.
// master = the writer itself, slave = whoever feeds bytes and sinks writes.
interface tilemem_writer_if #(
    parameter int ZOOM = 0
);
    localparam int AW = 13 - 2 * ZOOM;
    localparam int RB = 6 - ZOOM;
    localparam int CB = 7 - ZOOM;

    logic [7:0]    char_i;
    logic          char_valid_i;
    logic          char_ready_o;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          write_en;
    logic [CB-1:0] cursor_col;
    logic [RB-1:0] cursor_row;

    modport master (
        input  char_i,
        input  char_valid_i,
        output char_ready_o,
        output waddr,
        output wdata,
        output write_en,
        output cursor_col,
        output cursor_row
    );

    modport slave (
        output char_i,
        output char_valid_i,
        input  char_ready_o,
        input  waddr,
        input  wdata,
        input  write_en,
        input  cursor_col,
        input  cursor_row
    );

endinterface

// File: rtl/tilemem_writer.sv
// Console writer for the character tile RAM. Accepts bytes, handles CR/LF/
// BS/FF, writes printable codes at the text cursor and clears the screen or
// the current line one cell per cycle. Address map is {row, col}; columns
// at or beyond COLS are never touched. There is no scrolling: a newline on
// the last row wraps to row 0 and clears it.
module tilemem_writer
    import tilemem_writer_pkg::*;
#(
    parameter int         ZOOM = 0,
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic clk,
    input  logic resetn,
    tilemem_writer_if.master bus
);

    localparam int AW   = 13 - 2 * ZOOM;
    localparam int RB   = 6 - ZOOM;
    localparam int CB   = 7 - ZOOM;
    localparam int COLS = 80 >> ZOOM;
    localparam int ROWS = 60 >> ZOOM;

    localparam logic [CB-1:0] COL_ZERO = {CB{1'b0}};
    localparam logic [CB-1:0] COL_ONE  = {{(CB-1){1'b0}}, 1'b1};
    localparam logic [CB-1:0] COL_LAST = CB'(COLS - 1);
    localparam logic [RB-1:0] ROW_ZERO = {RB{1'b0}};
    localparam logic [RB-1:0] ROW_ONE  = {{(RB-1){1'b0}}, 1'b1};
    localparam logic [RB-1:0] ROW_LAST = RB'(ROWS - 1);

    tw_state_e     state_r, state_s;
    logic [RB-1:0] row_r, row_s;
    logic [CB-1:0] col_r, col_s;
    logic [RB-1:0] clr_row_r, clr_row_s;
    logic [CB-1:0] clr_col_r, clr_col_s;
    logic [AW-1:0] waddr_r, waddr_s;
    logic [7:0]    wdata_r, wdata_s;
    logic          write_en_r, write_en_s;
    logic          ready_r, ready_s;

    logic          accept_s;
    logic [RB-1:0] row_wrap_s;
    char_class_e   cls_s;

    // Handshake, newline target row and byte class derived from current state.
    always_comb begin
        accept_s   = bus.char_valid_i & ready_r;
        row_wrap_s = (row_r == ROW_LAST) ? ROW_ZERO : (row_r + ROW_ONE);
        cls_s      = classify(bus.char_i);
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        col_s      = col_r;
        clr_row_s  = clr_row_r;
        clr_col_s  = clr_col_r;
        waddr_s    = waddr_r;
        wdata_s    = wdata_r;
        write_en_s = 1'b0;

        case (state_r)
            TW_CLRALL: begin
                write_en_s = 1'b1;
                waddr_s    = {clr_row_r, clr_col_r};
                wdata_s    = FILL;
                if (clr_col_r == COL_LAST) begin
                    clr_col_s = COL_ZERO;
                    if (clr_row_r == ROW_LAST) begin
                        clr_row_s = ROW_ZERO;
                        row_s     = ROW_ZERO;
                        col_s     = COL_ZERO;
                        state_s   = TW_IDLE;
                    end else begin
                        clr_row_s = clr_row_r + ROW_ONE;
                    end
                end else begin
                    clr_col_s = clr_col_r + COL_ONE;
                end
            end

            TW_CLRLN: begin
                write_en_s = 1'b1;
                waddr_s    = {row_r, clr_col_r};
                wdata_s    = FILL;
                if (clr_col_r == COL_LAST) begin
                    clr_col_s = COL_ZERO;
                    state_s   = TW_IDLE;
                end else begin
                    clr_col_s = clr_col_r + COL_ONE;
                end
            end

            TW_IDLE: begin
                if (accept_s) begin
                    case (cls_s)
                        CC_PRINT: begin
                            write_en_s = 1'b1;
                            waddr_s    = {row_r, col_r};
                            wdata_s    = bus.char_i;
                            if (col_r == COL_LAST) begin
                                col_s     = COL_ZERO;
                                row_s     = row_wrap_s;
                                clr_col_s = COL_ZERO;
                                state_s   = TW_CLRLN;
                            end else begin
                                col_s = col_r + COL_ONE;
                            end
                        end
                        CC_CR: begin
                            col_s = COL_ZERO;
                        end
                        CC_LF: begin
                            col_s     = COL_ZERO;
                            row_s     = row_wrap_s;
                            clr_col_s = COL_ZERO;
                            state_s   = TW_CLRLN;
                        end
                        CC_BS: begin
                            if (col_r != COL_ZERO) begin
                                col_s      = col_r - COL_ONE;
                                write_en_s = 1'b1;
                                waddr_s    = {row_r, col_r - COL_ONE};
                                wdata_s    = FILL;
                            end else begin
                                col_s = col_r;
                            end
                        end
                        CC_FF: begin
                            row_s     = ROW_ZERO;
                            col_s     = COL_ZERO;
                            clr_row_s = ROW_ZERO;
                            clr_col_s = COL_ZERO;
                            state_s   = TW_CLRALL;
                        end
                        default: begin
                            state_s = state_r;
                        end
                    endcase
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                row_s     = ROW_ZERO;
                col_s     = COL_ZERO;
                clr_row_s = ROW_ZERO;
                clr_col_s = COL_ZERO;
                state_s   = TW_CLRALL;
            end
        endcase

        ready_s = (state_s == TW_IDLE);
    end

    // State, cursor, clear counter and registered RAM/handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= TW_CLRALL;
            row_r      <= ROW_ZERO;
            col_r      <= COL_ZERO;
            clr_row_r  <= ROW_ZERO;
            clr_col_r  <= COL_ZERO;
            waddr_r    <= {AW{1'b0}};
            wdata_r    <= FILL;
            write_en_r <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            row_r      <= row_s;
            col_r      <= col_s;
            clr_row_r  <= clr_row_s;
            clr_col_r  <= clr_col_s;
            waddr_r    <= waddr_s;
            wdata_r    <= wdata_s;
            write_en_r <= write_en_s;
            ready_r    <= ready_s;
        end
    end

    assign bus.waddr        = waddr_r;
    assign bus.wdata        = wdata_r;
    assign bus.write_en     = write_en_r;
    assign bus.char_ready_o = ready_r;
    assign bus.cursor_col   = col_r;
    assign bus.cursor_row   = row_r;

endmodule

// File: tb/tb_tilemem_writer.sv
// Directed bench for tilemem_writer (ZOOM=0, 80x60). Expected RAM writes are
// pushed to a scoreboard queue when each byte is driven and popped by a
// monitor as write_en pulses arrive; cursor/handshake values are compared
// against a small cursor model.
module tb_tilemem_writer;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic clk;
    logic resetn;

    tilemem_writer_if #(.ZOOM(0)) bus ();

    tilemem_writer #(.ZOOM(0), .FILL(8'h20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [20:0] sb[$];
    int m_row = 0;
    int m_col = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ent(input int r, input int c, input logic [7:0] d);
        logic [5:0] rr;
        logic [6:0] cc;
        rr = 6'(r);
        cc = 7'(c);
        return {rr, cc, d};
    endfunction

    task automatic push_line(input int r);
        for (int c = 0; c < COLS; c++) sb.push_back(ent(r, c, 8'h20));
    endtask

    task automatic push_screen();
        for (int r = 0; r < ROWS; r++) push_line(r);
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        push_line(m_row);
    endtask

    // Cursor model: records the writes a byte must cause, in order.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                sb.push_back(ent(m_row, m_col, 8'h20));
            end
        end else if (b == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            push_screen();
        end else if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
            sb.push_back(ent(m_row, m_col, b));
            if (m_col == COLS - 1) model_newline();
            else m_col++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 0;
        @(negedge clk);
        while (bus.char_ready_o !== 1'b1 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20000) chk("ready_timeout", 32'(bus.char_ready_o), 32'd1);
        model_byte(b);
        bus.char_i       = b;
        bus.char_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.char_ready_o !== 1'b1) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_ready"}, 32'(bus.char_ready_o), 32'd1);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_row"}, 32'(bus.cursor_row), 32'(m_row));
        chk({tag, "_col"}, 32'(bus.cursor_col), 32'(m_col));
    endtask

    // Scoreboard consumer: each write strobe must equal the oldest expected write.
    always @(negedge clk) begin
        logic [20:0] e;
        if (resetn === 1'b1 && bus.write_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.waddr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("waddr", 32'(bus.waddr), 32'(e[20:8]));
                chk("wdata", 32'(bus.wdata), 32'(e[7:0]));
            end
        end
    end

    initial begin
        bus.char_i       = 8'h00;
        bus.char_valid_i = 1'b0;
        resetn           = 1'b0;

        // 1: reset values, then the full power-up clear.
        repeat (3) @(negedge clk);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", 32'(bus.wdata), 32'h20);
        chk("rst_we", 32'(bus.write_en), 32'd0);
        chk("rst_ready", 32'(bus.char_ready_o), 32'd0);
        chk("rst_row", 32'(bus.cursor_row), 32'd0);
        chk("rst_col", 32'(bus.cursor_col), 32'd0);
        push_screen();
        resetn = 1'b1;
        wait_idle("t1");
        chk_cursor("t1");

        // 2: two printables.
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle("t2");
        chk("t2_col", 32'(bus.cursor_col), 32'd2);
        chk_cursor("t2");

        // Ignored codes leave cursor and RAM alone.
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h1B);
        wait_idle("ign");
        chk_cursor("ign");

        // 3: a full row of 'x' wraps to row 1 and clears it.
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte(8'h78);
        wait_idle("t3");
        chk("t3_row", 32'(bus.cursor_row), 32'd1);
        chk("t3_col", 32'(bus.cursor_col), 32'd0);

        // 4: backspace mid-line and at column 0.
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h08);
        wait_idle("t4a");
        chk("t4_col", 32'(bus.cursor_col), 32'd2);
        send_byte(8'h0D);
        send_byte(8'h08);
        wait_idle("t4b");
        chk_cursor("t4b");

        // 5a: LF on the last row wraps to row 0 and clears it.
        while (m_row != ROWS - 1) send_byte(8'h0A);
        wait_idle("t5pre");
        chk("t5_row59", 32'(bus.cursor_row), 32'd59);
        send_byte(8'h0A);
        chk("t5_ready_drop", 32'(bus.char_ready_o), 32'd0);
        wait_idle("t5a");
        chk("t5a_row", 32'(bus.cursor_row), 32'd0);
        chk("t5a_col", 32'(bus.cursor_col), 32'd0);

        // 5b: printable in the very last cell.
        while (m_row != ROWS - 1) send_byte(8'h0A);
        for (int i = 0; i < COLS; i++) send_byte(8'h7A);
        wait_idle("t5b");
        chk("t5b_row", 32'(bus.cursor_row), 32'd0);
        chk("t5b_col", 32'(bus.cursor_col), 32'd0);

        // 5c: form feed mid-text clears the whole screen.
        send_byte(8'h48);
        send_byte(8'hC9);
        send_byte(8'h0C);
        chk("t5c_ready_drop", 32'(bus.char_ready_o), 32'd0);
        wait_idle("t5c");
        chk_cursor("t5c");

        // 6: reset in the middle of a line clear.
        send_byte(8'h0A);
        repeat (10) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_we", 32'(bus.write_en), 32'd0);
        chk("t6_waddr", 32'(bus.waddr), 32'd0);
        chk("t6_ready", 32'(bus.char_ready_o), 32'd0);
        chk("t6_row", 32'(bus.cursor_row), 32'd0);
        sb.delete();
        m_row = 0;
        m_col = 0;
        push_screen();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_idle("t6");
        chk_cursor("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
